srcnn_output_packer: RTL and testbench
======================================

# srcnn_output_packer

Final stage of the super-resolution datapath. Consumes the 3-channel activation stream produced by the SRCNN network, clamps each signed activation to an 8-bit pixel, packs RGB888, and regenerates AXI4-Stream video framing (start-of-frame on tuser, end-of-line on tlast) from row/column counters. It also reports per-frame saturation statistics. A two-entry skid buffer isolates the network's ready path from the video sink.

## Interface
Parameters:
- Height, 600: active lines per frame.
- Width, 800: active pixels per line.
- ActivationWidth, 10: bits per channel on the input; two's-complement signed.

Ports:
- clock_i  in  1  single clock domain.
- reset_i  in  1  synchronous, active-low reset.
- slave_valid_i  in  1  input beat valid.
- slave_ready_o  out  1  block can accept a beat.
- slave_data_i  in  3*ActivationWidth  channel c at [c*ActivationWidth +: ActivationWidth].
- master_tvalid_o  out  1  output beat valid.
- master_tready_i  in  1  sink accepts the beat.
- master_tdata_o  out  24  channel c clamped to [8c +: 8].
- master_tuser_o  out  1  first pixel of the frame (row 0, col 0).
- master_tlast_o  out  1  last pixel of a line (col Width-1).
- clip_count_o  out  32  number of channel samples clamped in the last completed frame.
- frame_done_o  out  1  one-cycle pulse when a frame's last pixel has been accepted.

## Operation
- Clamp, per channel: a value below 0 gives 0; a value above 255 gives 255; otherwise the low 8 bits. The clamp is combinational on slave_data_i before registering.
- A sample counts as clipped when its value is below 0 or above 255. Each pixel contributes 0–3 clips.
- Counters col (0..Width-1) and row (0..Height-1) advance on every input handshake (slave_valid_i & slave_ready_o).
  - col wraps to 0 at Width-1, then row increments.
  - row wraps to 0 after Height-1; the wrap ends the frame.
- Framing flags are computed from the counter values at acceptance and travel with the beat through the buffer:
  - tuser = (row==0 && col==0).
  - tlast = (col==Width-1).
- Skid buffer has two registers:
  - The output register drives master_*.
  - The skid register holds a beat accepted while the output register is stalled.
  - slave_ready_o is registered and equals "skid register empty".
- Beat movement:
  - If the output register is empty or being consumed (master_tready_i=1), the skid beat (if any), else the incoming beat, loads into it.
  - An incoming beat that cannot load into the output register goes to the skid register.
  - Ordering is strictly FIFO.
- Statistics:
  - clip_acc accumulates clips on each accepted beat.
  - On acceptance of the frame's last pixel (row==Height-1, col==Width-1), clip_count_o <= clip_acc + this pixel's clips, clip_acc <= 0, and frame_done_o pulses.
  - clip_acc saturates at 2^32-1.
- Reset (reset_i=0 at a clock edge):
  - Both buffer entries are invalidated.
  - row, col and clip_acc are cleared.
  - All outputs go to 0, including slave_ready_o and clip_count_o.
  - A mid-frame reset discards in-flight beats; the next accepted beat carries tuser=1.

## Timing
- Latency: a beat accepted at edge N appears on master_* after edge N (valid in cycle N+1) when the output register is free.
- Throughput: 1 pixel/clock with master_tready_i held at 1.
- slave_ready_o:
  - Rises the cycle after reset is released.
  - Falls the cycle after a beat enters the skid register.
  - Rises the cycle after the skid register drains.
- AXI rule: while master_tvalid_o=1 and master_tready_i=0, master_tdata_o, tuser and tlast are held stable.
- A sink stall of any length loses no beats. At most 2 beats are buffered.
- frame_done_o and the clip_count_o update occur in the cycle after the last pixel's input handshake, independent of output stalls.
- Simultaneous output consume and input accept with the skid register full: the skid beat moves to the output register and the incoming beat is not accepted (slave_ready_o is already 0).

## Test plan
Use Height=2, Width=3 for all scenarios.
- Reset release, then 6 beats streamed with tready=1:
  - Expect 6 outputs at 1/clock with 1-cycle latency.
  - tuser on beat 0 only; tlast on beats 2 and 5.
  - frame_done_o pulses once; clip_count_o=0.
- Clamp values:
  - Input channels (-1, 255, 256) give tdata=0xFF_FF_00 (ch2=0xFF, ch1=0xFF, ch0=0x00).
  - Input (-512, 511, 0) gives 0x00_FF_00.
  - Over one frame containing both pixels, clip_count_o=4.
- Back-pressure: hold tready=0 for 5 cycles while valid is 1.
  - Exactly 2 beats accepted; slave_ready_o=0 from the cycle after the second.
  - Outputs stay stable; on release all beats arrive in order with no duplicates.
- Random valid/ready toggling over 4 frames: the output sequence equals the input sequence, and framing flags repeat every 6 beats.
- Assert reset_i=0 for 1 cycle after 4 beats of a frame:
  - All outputs are 0 during reset.
  - The next beat carries tuser=1; clip_count_o=0.
- Saturation statistic across two frames: frame 1 has 3 clipped samples, frame 2 has 0. clip_count_o reads 3, then 0.

Source files
------------

// File: rtl/srcnn_output_packer.sv
// rtl/srcnn_output_packer.sv - SRCNN activation clamp, RGB888 pack, AXI4-Stream video framing and clip statistics
//
// Ports:
//   clock_i          single clock domain
//   reset_i          synchronous active-low reset
//   slave_valid_i    input beat valid
//   slave_ready_o    input beat accepted when high (registered, equals "skid register empty")
//   slave_data_i     3 signed activations, channel c at [c*ActivationWidth +: ActivationWidth]
//   master_tvalid_o  output beat valid
//   master_tready_i  sink accepts the output beat
//   master_tdata_o   RGB888, clamped channel c at [8c +: 8]
//   master_tuser_o   start of frame (row 0, col 0)
//   master_tlast_o   end of line (col Width-1)
//   clip_count_o     clamped samples in the last completed frame
//   frame_done_o     one-cycle pulse after the frame's last pixel is accepted
module srcnn_output_packer #(
    parameter int Height          = 600,
    parameter int Width           = 800,
    parameter int ActivationWidth = 10
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           slave_valid_i,
    output logic                           slave_ready_o,
    input  logic [3*ActivationWidth-1:0]   slave_data_i,
    output logic                           master_tvalid_o,
    input  logic                           master_tready_i,
    output logic [23:0]                    master_tdata_o,
    output logic                           master_tuser_o,
    output logic                           master_tlast_o,
    output logic [31:0]                    clip_count_o,
    output logic                           frame_done_o
);

    localparam int RowW = (Height > 1) ? $clog2(Height) : 1;
    localparam int ColW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);
    localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);

    typedef struct packed {
        logic        user;
        logic        last;
        logic [23:0] data;
    } beat_t;

    // ------------------------------------------------------------------
    // Per-channel clamp of the incoming activations to 0..255
    // ------------------------------------------------------------------
    logic [23:0] pix_data;
    logic [2:0]  pix_clip;
    logic [1:0]  pix_clips;

    for (genvar c = 0; c < 3; c++) begin : g_clamp
        logic [ActivationWidth-1:0] ch;
        logic                       neg;
        logic                       over;

        assign ch   = slave_data_i[c*ActivationWidth +: ActivationWidth];
        assign neg  = ch[ActivationWidth-1];
        // Unsigned compare is safe here because it only matters when the sign bit is clear.
        assign over = !neg && (ch > ActivationWidth'(255));
        assign pix_data[8*c +: 8] = neg ? 8'h00 : (over ? 8'hFF : ch[7:0]);
        assign pix_clip[c]        = neg | over;
    end

    assign pix_clips = 2'(pix_clip[0]) + 2'(pix_clip[1]) + 2'(pix_clip[2]);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    beat_t            out_beat_q, out_beat_d;
    logic             out_valid_q, out_valid_d;
    beat_t            skid_beat_q, skid_beat_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [31:0]      clip_acc_q, clip_acc_d;
    logic [31:0]      clip_count_q, clip_count_d;
    logic             frame_done_q, frame_done_d;

    logic             accept;
    logic             out_free;
    logic             col_last;
    logic             row_last;
    beat_t            in_beat;
    logic [32:0]      acc_sum;
    logic [31:0]      acc_sat;

    assign accept   = slave_valid_i & ready_q;
    assign out_free = ~out_valid_q | master_tready_i;
    assign col_last = (col_q == LastCol);
    assign row_last = (row_q == LastRow);

    // Framing is decided at acceptance and travels with the beat.
    assign in_beat.user = (row_q == '0) && (col_q == '0);
    assign in_beat.last = col_last;
    assign in_beat.data = pix_data;

    assign acc_sum = {1'b0, clip_acc_q} + 33'(pix_clips);
    assign acc_sat = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];

    // ------------------------------------------------------------------
    // Skid buffer: output register first, skid register only on stall.
    // ready_q mirrors "skid empty", so an accept never coincides with a
    // full skid register and the skid-to-output move never drops a beat.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_beat_d = in_beat;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat;
        end

        ready_d = ~skid_valid_d;
    end

    // ------------------------------------------------------------------
    // Raster counters and per-frame clip statistics (input side, so they
    // are unaffected by sink stalls)
    // ------------------------------------------------------------------
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        clip_acc_d   = clip_acc_q;
        clip_count_d = clip_count_q;
        frame_done_d = 1'b0;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end

            if (col_last && row_last) begin
                clip_count_d = acc_sat;
                clip_acc_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                clip_acc_d = acc_sat;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            out_beat_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_beat_q  <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            clip_acc_q   <= '0;
            clip_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_beat_q   <= out_beat_d;
            out_valid_q  <= out_valid_d;
            skid_beat_q  <= skid_beat_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clip_acc_q   <= clip_acc_d;
            clip_count_q <= clip_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign slave_ready_o   = ready_q;
    assign master_tvalid_o = out_valid_q;
    assign master_tdata_o  = out_beat_q.data;
    assign master_tuser_o  = out_beat_q.user;
    assign master_tlast_o  = out_beat_q.last;
    assign clip_count_o    = clip_count_q;
    assign frame_done_o    = frame_done_q;

endmodule

// File: tb/tb_srcnn_output_packer.sv
// tb/tb_srcnn_output_packer.sv - directed and random scoreboard bench for srcnn_output_packer
module tb_srcnn_output_packer;

    localparam int H  = 2;
    localparam int W  = 3;
    localparam int AW = 10;

    logic            clock = 1'b0;
    logic            reset_i = 1'b0;
    logic            slave_valid_i = 1'b0;
    logic            slave_ready_o;
    logic [3*AW-1:0] slave_data_i = '0;
    logic            master_tvalid_o;
    logic            master_tready_i = 1'b0;
    logic [23:0]     master_tdata_o;
    logic            master_tuser_o;
    logic            master_tlast_o;
    logic [31:0]     clip_count_o;
    logic            frame_done_o;

    srcnn_output_packer #(
        .Height(H),
        .Width(W),
        .ActivationWidth(AW)
    ) dut (
        .clock_i(clock),
        .reset_i(reset_i),
        .slave_valid_i(slave_valid_i),
        .slave_ready_o(slave_ready_o),
        .slave_data_i(slave_data_i),
        .master_tvalid_o(master_tvalid_o),
        .master_tready_i(master_tready_i),
        .master_tdata_o(master_tdata_o),
        .master_tuser_o(master_tuser_o),
        .master_tlast_o(master_tlast_o),
        .clip_count_o(clip_count_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clock = ~clock;

    // Expected beat: {user, last, data}
    logic [25:0]     exp_q[$];
    int              total = 0;
    int              bad = 0;
    int              m_row = 0;
    int              m_col = 0;
    longint          m_acc = 0;
    logic [31:0]     m_clip = '0;
    int              n_acc = 0;
    int              n_out = 0;
    int              n_fd = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3*AW-1:0] pack(input int c0, input int c1, input int c2);
        return {10'(c2), 10'(c1), 10'(c0)};
    endfunction

    function automatic void clampm(input logic [AW-1:0] x, output logic [7:0] y, output int clip);
        int s;
        s = $signed(x);
        if (s < 0) begin
            y = 8'h00; clip = 1;
        end else if (s > 255) begin
            y = 8'hFF; clip = 1;
        end else begin
            y = s[7:0]; clip = 0;
        end
    endfunction

    // One clock: drive at negedge, check output beat vs scoreboard, model acceptance,
    // then check frame statistics just after the edge.
    task automatic cyc(input logic v, input logic [3*AW-1:0] d, input logic r);
        logic        acc;
        logic        ohs;
        logic        fd_next;
        logic [23:0] dd;
        logic [7:0]  y;
        logic        u;
        logic        l;
        int          cl;
        int          clips;
        @(negedge clock);
        slave_valid_i   = v;
        slave_data_i    = d;
        master_tready_i = r;
        acc     = v && slave_ready_o;
        ohs     = master_tvalid_o && r;
        fd_next = 1'b0;

        chk("tvalid", master_tvalid_o, exp_q.size() != 0);
        if (master_tvalid_o && exp_q.size() != 0) begin
            chk("beat", {master_tuser_o, master_tlast_o, master_tdata_o}, exp_q[0]);
        end
        if (ohs && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_out++;
        end

        if (acc) begin
            clips = 0;
            for (int c = 0; c < 3; c++) begin
                clampm(d[c*AW +: AW], y, cl);
                dd[c*8 +: 8] = y;
                clips += cl;
            end
            u = (m_row == 0) && (m_col == 0);
            l = (m_col == W - 1);
            exp_q.push_back({u, l, dd});
            m_acc = m_acc + clips;
            if (m_acc > 64'hFFFF_FFFF) m_acc = 64'hFFFF_FFFF;
            if (m_row == H - 1 && m_col == W - 1) begin
                m_clip  = m_acc[31:0];
                m_acc   = 0;
                fd_next = 1'b1;
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
            n_acc++;
        end

        @(posedge clock);
        #1;
        chk("frame_done", frame_done_o, fd_next);
        chk("clip_count", clip_count_o, m_clip);
        if (frame_done_o) n_fd++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_i         = 1'b0;
        slave_valid_i   = 1'b0;
        master_tready_i = 1'b0;
        slave_data_i    = '0;
        @(posedge clock);
        #1;
        chk("rst_ready", slave_ready_o, 0);
        chk("rst_tvalid", master_tvalid_o, 0);
        chk("rst_tdata", master_tdata_o, 0);
        chk("rst_tuser", master_tuser_o, 0);
        chk("rst_tlast", master_tlast_o, 0);
        chk("rst_clip", clip_count_o, 0);
        chk("rst_fdone", frame_done_o, 0);
        exp_q.delete();
        m_row  = 0;
        m_col  = 0;
        m_acc  = 0;
        m_clip = '0;
        @(negedge clock);
        reset_i = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_rise", slave_ready_o, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cyc(1'b0, '0, 1'b1);
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        int a0;
        int o0;
        int f0;

        // Streaming one frame at full rate
        do_reset();
        a0 = n_acc; o0 = n_out; f0 = n_fd;
        cyc(1'b1, pack(1, 2, 3), 1'b1);
        chk("latency", master_tvalid_o, 1);
        for (int i = 1; i < 6; i++) cyc(1'b1, pack(10 * i, 20 * i, 40 * i), 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("stream_acc", n_acc - a0, 6);
        chk("stream_out", n_out - o0, 6);
        chk("stream_fd", n_fd - f0, 1);
        chk("stream_clip", clip_count_o, 0);

        // Clamp values over one frame
        cyc(1'b1, pack(-1, 255, 256), 1'b1);
        chk("clamp_a", master_tdata_o, 24'hFFFF00);
        cyc(1'b1, pack(-512, 511, 0), 1'b1);
        chk("clamp_b", master_tdata_o, 24'h00FF00);
        for (int i = 0; i < 4; i++) cyc(1'b1, pack(0, 0, 0), 1'b1);
        chk("clamp_clips", clip_count_o, 4);
        drain();

        // Back-pressure: sink stalled for 5 cycles
        a0 = n_acc;
        cyc(1'b1, pack(5, 6, 7), 1'b0);
        cyc(1'b1, pack(8, 9, 10), 1'b0);
        chk("bp_ready_low", slave_ready_o, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, pack(100 + i, 1, 2), 1'b0);
        chk("bp_accepted", n_acc - a0, 2);
        drain();

        // Random valid/ready over 4 frames
        a0 = n_acc;
        for (int k = 0; k < 400 && n_acc < a0 + 24; k++) begin
            cyc(1'($urandom_range(0, 1)), 30'($urandom()), 1'($urandom_range(0, 1)));
        end
        chk("rand_accepted", n_acc - a0, 24);
        drain();

        // Mid-frame reset after 4 beats of a frame
        for (int k = 0; k < 20 && (m_row != 0 || m_col != 0); k++) cyc(1'b1, pack(1, 1, 1), 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, pack(300, 2, 3), 1'b1);
        do_reset();
        cyc(1'b1, pack(7, 8, 9), 1'b1);
        chk("post_rst_tuser", master_tuser_o, 1);
        chk("post_rst_clip", clip_count_o, 0);

        // Saturation statistic: 3 clips then 0 clips
        do_reset();
        cyc(1'b1, pack(300, -5, 0), 1'b1);
        cyc(1'b1, pack(0, 0, 400), 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, pack(10, 20, 30), 1'b1);
        chk("sat_frame1", clip_count_o, 3);
        for (int i = 0; i < 6; i++) cyc(1'b1, pack(i, 255, 0), 1'b1);
        chk("sat_frame2", clip_count_o, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
